// File: rtl/_8b10b.sv
// Shared 8b10b definitions: pair10 word type, K28.5 comma symbols, aligner state enum
// and a helper that extracts the candidate word at a bit offset of a 40-bit window.
package _8b10b;

   typedef logic [19:0] pair10;
   typedef logic [9:0]  sym10;

   localparam sym10 K28_5_RDN = 10'b0011111010;
   localparam sym10 K28_5_RDP = 10'b1100000101;

   typedef enum logic [1:0] {StHunt, StSync, StLocked} align_state_e;

   // Candidate at offset o is window[39-o : 20-o].
   function automatic pair10 cand_word(input logic [39:0] w, input logic [4:0] o);
      logic [39:0] s;
      s = w << o;
      return s[39:20];
   endfunction

   function automatic logic is_comma(input sym10 s);
      return (s == K28_5_RDN) || (s == K28_5_RDP);
   endfunction

endpackage

// File: rtl/pair10_comma_search.sv
// Combinational K28.5 search over the 40-bit window: per-offset hit vector, lowest hit
// offset and whether the given offset hits. Commas are only matched in the symbol-0 slot.
module pair10_comma_search
   import _8b10b::*;
(
   input  logic [39:0] window,
   input  logic [4:0]  off,
   output logic [19:0] hit,
   output logic [4:0]  low_off,
   output logic        hit_at_off
);

   logic [39:0] sh;
   logic [31:0] hit_ext;

   always_comb begin
      hit = '0;
      sh  = '0;
      for (int o = 0; o < 20; o++) begin
         sh     = window << o;
         hit[o] = is_comma(sh[39:30]);
      end
   end

   // Scan downwards so the lowest hitting offset is the one left standing.
   always_comb begin
      low_off = '0;
      for (int o = 19; o >= 0; o--) begin
         if (hit[o]) low_off = 5'(o);
      end
   end

   assign hit_ext    = {12'b0, hit};
   assign hit_at_off = hit_ext[off];

endmodule

// File: rtl/pair10_aligner.sv
// pair10 comma aligner: hunts for K28.5 in a 40-bit window, locks after LOCK_COUNT commas
// at one offset. Optional misplaced-comma counter via `PAIR10_ALIGNER_ERR_COUNT_EN.
module pair10_aligner
   import _8b10b::*;
#(
   parameter int unsigned LOCK_COUNT   = 4,
   parameter int unsigned UNLOCK_COUNT = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   input  pair10       in_data,
   input  logic        in_valid,
   output pair10       out_data,
   output logic        out_valid,
   output logic        out_locked,
   output logic [4:0]  out_offset
`ifdef PAIR10_ALIGNER_ERR_COUNT_EN
   ,
   output logic [15:0] err_count
`endif
);

   localparam logic [3:0] LockCnt   = 4'(LOCK_COUNT);
   localparam logic [3:0] UnlockCnt = 4'(UNLOCK_COUNT);

   align_state_e state_q, state_d;
   logic [4:0]   off_q, off_d;
   logic [3:0]   good_q, good_d, good_inc;
   logic [3:0]   bad_q, bad_d, bad_inc;
   pair10        prev_q;

   logic [39:0]  window;
   logic [19:0]  hit;
   logic [4:0]   low_off;
   logic         hit_at_off;
   logic         any_hit;

   assign window   = {prev_q, in_data};
   assign any_hit  = |hit;
   assign good_inc = good_q + 4'd1;
   assign bad_inc  = bad_q + 4'd1;

   pair10_comma_search u_search (
      .window     (window),
      .off        (off_q),
      .hit        (hit),
      .low_off    (low_off),
      .hit_at_off (hit_at_off)
   );

   always_comb begin
      state_d = state_q;
      off_d   = off_q;
      good_d  = good_q;
      bad_d   = bad_q;
      if (in_valid) begin
         case (state_q)
            StHunt: begin
               if (any_hit) begin
                  off_d   = low_off;
                  good_d  = 4'd1;
                  bad_d   = 4'd0;
                  state_d = (LockCnt == 4'd1) ? StLocked : StSync;
               end
            end
            StSync: begin
               if (hit_at_off) begin
                  good_d = good_inc;
                  if (good_inc == LockCnt) begin
                     state_d = StLocked;
                     bad_d   = 4'd0;
                  end
               end else if (any_hit) begin
                  off_d  = low_off;
                  good_d = 4'd1;
               end
            end
            StLocked: begin
               if (hit_at_off) begin
                  bad_d = 4'd0;
               end else if (any_hit) begin
                  bad_d = bad_inc;
                  if (bad_inc == UnlockCnt) begin
                     state_d = StHunt;
                     good_d  = 4'd0;
                     bad_d   = 4'd0;
                  end
               end
            end
            default: state_d = StHunt;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StHunt;
         off_q      <= '0;
         good_q     <= '0;
         bad_q      <= '0;
         prev_q     <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_locked <= 1'b0;
         out_offset <= '0;
      end else begin
         state_q    <= state_d;
         off_q      <= off_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
         out_valid  <= in_valid;
         out_locked <= (state_d == StLocked);
         out_offset <= off_d;
         if (in_valid) begin
            prev_q   <= in_data;
            // Output word is taken at the offset being adopted on this cycle.
            out_data <= cand_word(window, off_d);
         end
      end
   end

`ifdef PAIR10_ALIGNER_ERR_COUNT_EN
   logic misplaced;
   assign misplaced = in_valid && (state_q == StLocked) && !hit_at_off && any_hit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count <= '0;
      end else if (misplaced && (err_count != 16'hFFFF)) begin
         err_count <= err_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pair10_aligner.sv
// Self-checking bench for pair10_aligner: constant vector table, directed lock/unlock/reset
// sequences, then randomized streams checked against a behavioural model.
module tb_pair10_aligner;

   localparam int LOCKN   = 4;
   localparam int UNLOCKN = 4;
   localparam logic [9:0]  KN = 10'b0011111010;
   localparam logic [9:0]  KP = 10'b1100000101;
   localparam logic [19:0] CW = {KN, 10'b0};
   localparam logic [19:0] MW = {5'b0, KN, 5'b0};

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [19:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic [19:0] out_data;
   logic        out_valid;
   logic        out_locked;
   logic [4:0]  out_offset;
`ifdef PAIR10_ALIGNER_ERR_COUNT_EN
   logic [15:0] err_count;
`endif

   always #5 clk = ~clk;

   pair10_aligner #(.LOCK_COUNT(LOCKN), .UNLOCK_COUNT(UNLOCKN)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_locked (out_locked),
      .out_offset (out_offset)
`ifdef PAIR10_ALIGNER_ERR_COUNT_EN
      ,
      .err_count  (err_count)
`endif
   );

   int npass = 0;
   int ntotal = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: HUNT=0, SYNC=1, LOCKED=2.
   int          m_state, m_off, m_good, m_bad, m_err;
   logic [19:0] m_prev;
   logic        e_valid, e_locked;
   logic [19:0] e_data;
   int          e_off;

   task automatic model_reset();
      m_state = 0; m_off = 0; m_good = 0; m_bad = 0; m_err = 0; m_prev = '0;
      e_valid = 0; e_locked = 0; e_data = '0; e_off = 0;
   endtask

   function automatic bit comma_at(input logic [39:0] w, input int o);
      logic [9:0] s;
      s = w[39-o -: 10];
      return (s == KN) || (s == KP);
   endfunction

   task automatic model_step(input logic [19:0] d, input logic v);
      logic [39:0] w;
      int lowest;
      bit at;
      if (!v) begin
         e_valid = 0;
         return;
      end
      w = {m_prev, d};
      lowest = -1;
      for (int o = 19; o >= 0; o--) if (comma_at(w, o)) lowest = o;
      at = comma_at(w, m_off);
      if (lowest >= 0) begin
         case (m_state)
            0: begin
               m_off = lowest; m_good = 1;
               m_state = (LOCKN == 1) ? 2 : 1;
            end
            1: if (at) begin
               m_good++;
               if (m_good == LOCKN) begin m_state = 2; m_bad = 0; end
            end else begin
               m_off = lowest; m_good = 1;
            end
            default: if (at) m_bad = 0;
            else begin
               m_bad++;
               if (m_err < 65535) m_err++;
               if (m_bad == UNLOCKN) begin m_state = 0; m_good = 0; m_bad = 0; end
            end
         endcase
      end
      e_valid  = 1;
      e_data   = w[39-m_off -: 20];
      e_locked = (m_state == 2);
      e_off    = m_off;
      m_prev   = d;
   endtask

   task automatic cmp_model();
      chk("valid", out_valid, e_valid);
      chk("locked", out_locked, e_locked);
      chk("offset", out_offset, e_off);
      chk("data", out_data, e_data);
`ifdef PAIR10_ALIGNER_ERR_COUNT_EN
      chk("err_count", err_count, m_err);
`endif
   endtask

   task automatic drive(input logic [19:0] d, input logic v);
      @(negedge clk);
      in_data  = d;
      in_valid = v;
      @(posedge clk);
      model_step(d, v);
      #1;
      cmp_model();
   endtask

   // Mid-cycle reset pulse; outputs must clear without waiting for a clock edge.
   task automatic pulse_reset();
      @(negedge clk);
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("rst_valid", out_valid, 0);
      chk("rst_locked", out_locked, 0);
      chk("rst_offset", out_offset, 0);
      chk("rst_data", out_data, 0);
`ifdef PAIR10_ALIGNER_ERR_COUNT_EN
      chk("rst_err", err_count, 0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   function automatic logic [19:0] rotr(input logic [19:0] w, input int d);
      logic [39:0] x;
      x = {w, w} >> d;
      return x[19:0];
   endfunction

   typedef struct {
      logic [19:0] din;
      logic        vin;
      logic        ev;
      logic        el;
      logic [4:0]  eo;
      logic [19:0] ed;
   } vec_t;

   vec_t tbl[8];

   initial begin
      // Offset-0 comma stream: first word has no comma in the window (prev = 0).
      tbl[0] = '{CW, 1'b1, 1'b1, 1'b0, 5'd0, 20'h0};
      tbl[1] = '{CW, 1'b1, 1'b1, 1'b0, 5'd0, CW};
      tbl[2] = '{CW, 1'b0, 1'b0, 1'b0, 5'd0, CW};
      tbl[3] = '{CW, 1'b1, 1'b1, 1'b0, 5'd0, CW};
      tbl[4] = '{CW, 1'b1, 1'b1, 1'b0, 5'd0, CW};
      tbl[5] = '{CW, 1'b1, 1'b1, 1'b1, 5'd0, CW};
      tbl[6] = '{MW, 1'b1, 1'b1, 1'b1, 5'd0, CW};
      tbl[7] = '{MW, 1'b1, 1'b1, 1'b1, 5'd0, MW};

      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("init_valid", out_valid, 0);
      chk("init_locked", out_locked, 0);
      chk("init_data", out_data, 0);
      @(negedge clk);
      reset_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].din, tbl[i].vin);
         chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         chk($sformatf("tbl%0d_locked", i), out_locked, tbl[i].el);
         chk($sformatf("tbl%0d_offset", i), out_offset, tbl[i].eo);
         chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
      end

      // bad reaches 3, one correct comma clears it, then 3 more misplaced: still locked.
      drive(MW, 1); drive(CW, 1); drive(MW, 1); drive(MW, 1); drive(MW, 1); drive(CW, 1);
      chk("keep_lock", out_locked, 1);
      drive(MW, 1);
      chk("keep_lock_after", out_locked, 1);

      // Stream delayed by 7 bits.
      pulse_reset();
      drive(CW >> 7, 1);
      for (int i = 0; i < 6; i++) drive(rotr(CW, 7), 1);
      chk("off7_locked", out_locked, 1);
      chk("off7_offset", out_offset, 7);
      chk("off7_comma", out_data[19:10], KN);

      // Move to offset 3: 4 misplaced commas drop lock, 4 more relock.
      drive(rotr(CW, 3), 1);
      for (int i = 0; i < 3; i++) drive(rotr(CW, 3), 1);
      chk("unlock_pending", out_locked, 1);
      drive(rotr(CW, 3), 1);
      chk("unlock", out_locked, 0);
      for (int i = 0; i < 4; i++) drive(rotr(CW, 3), 1);
      chk("relock", out_locked, 1);
      chk("relock_offset", out_offset, 3);
`ifdef PAIR10_ALIGNER_ERR_COUNT_EN
      chk("err_four", err_count, 4);
`endif

      // Gapped valid during lock.
      pulse_reset();
      for (int i = 0; i < 10; i++) drive(CW, (i % 2) == 0);
      chk("gap_locked", out_locked, 1);
      chk("gap_valid_low", out_valid, 0);

      // Mid-lock reset, then LOCK_COUNT fresh commas (plus the prev-fill word).
      pulse_reset();
      for (int i = 0; i < 4; i++) drive(CW, 1);
      chk("post_rst_not_locked", out_locked, 0);
      drive(CW, 1);
      chk("post_rst_locked", out_locked, 1);

      // Randomized streams against the model.
      begin
         int ro;
         logic [19:0] w;
         ro = 0;
         for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 39) == 0) ro = $urandom_range(0, 19);
            if ($urandom_range(0, 499) == 0) pulse_reset();
            w = 20'($urandom);
            if ($urandom_range(0, 9) < 7)
               w = rotr({($urandom_range(0, 1) != 0) ? KP : KN, w[9:0]}, ro);
            drive(w, $urandom_range(0, 9) < 8);
         end
      end

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
